// File: rtl/i2s_transmit_24.sv
// I2S transmitter: accepts a left/right sample pair through a valid/ready
// handshake into a one-pair pending buffer, transfers it to the active words
// at each frame start and shifts it out MSB-first on sd_o with the I2S
// one-bit delay. sck_i/ws_i come from the clock generator in the clk_i domain.
module i2s_transmit_24 #(
  parameter int unsigned DATA_W = 24,
  parameter int unsigned SLOT_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              sck_i,
  input  logic              ws_i,
  input  logic [DATA_W-1:0] left_i,
  input  logic [DATA_W-1:0] right_i,
  input  logic              valid_i,
  output logic              ready_o,
  output logic              sd_o,
  output logic              underrun_o
);

  localparam int unsigned CNT_W = $clog2(SLOT_W + 1);
  localparam logic [CNT_W-1:0] CNT_IDLE = CNT_W'(SLOT_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_W - 1);
  localparam logic [CNT_W-1:0] CNT_DATA = CNT_W'(DATA_W);

  // ST_IDLE: no frame start seen since reset; ST_ARMED: slots are transmitted
  typedef enum logic {
    ST_IDLE,
    ST_ARMED
  } state_t;

  state_t              state_q, state_d;
  logic                sck_q, sck_d;
  logic                ws_last_q, ws_last_d;
  logic                pend_full_q, pend_full_d;
  logic [DATA_W-1:0]   pend_l_q, pend_l_d;
  logic [DATA_W-1:0]   pend_r_q, pend_r_d;
  logic [DATA_W-1:0]   act_l_q, act_l_d;
  logic [DATA_W-1:0]   act_r_q, act_r_d;
  logic [DATA_W-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                sd_q, sd_d;
  logic                underrun_q, underrun_d;

  logic                fall;
  logic                ws_trans;
  logic                frame_start;
  logic                slot_start;
  logic                accept;
  logic [DATA_W-1:0]   new_left;

  // Edge detection, handshake, frame-start transfer and bit serialisation
  always_comb begin
    sck_d       = sck_i;
    ws_last_d   = ws_last_q;
    state_d     = state_q;
    pend_full_d = pend_full_q;
    pend_l_d    = pend_l_q;
    pend_r_d    = pend_r_q;
    act_l_d     = act_l_q;
    act_r_d     = act_r_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    sd_d        = sd_q;
    underrun_d  = 1'b0;

    fall        = sck_q & ~sck_i;
    ws_trans    = fall & (ws_i != ws_last_q);
    frame_start = ws_trans & ws_last_q & ~ws_i;
    accept      = valid_i & ~pend_full_q;
    slot_start  = ws_trans & (frame_start | (state_q == ST_ARMED));
    new_left    = pend_full_q ? pend_l_q : '0;

    if (fall) begin
      ws_last_d = ws_i;
    end

    // accept and frame-start-with-full-pending are mutually exclusive,
    // so the pending-full updates below never collide
    if (accept) begin
      pend_l_d    = left_i;
      pend_r_d    = right_i;
      pend_full_d = 1'b1;
    end

    if (frame_start) begin
      state_d = ST_ARMED;
      if (pend_full_q) begin
        act_l_d     = pend_l_q;
        act_r_d     = pend_r_q;
        pend_full_d = 1'b0;
      end else begin
        act_l_d    = '0;
        act_r_d    = '0;
        underrun_d = 1'b1;
      end
    end

    // Left slot loads the word being latched this cycle; right slot uses
    // the word latched at the preceding frame start
    if (slot_start) begin
      shift_d = ws_i ? act_r_q : new_left;
      cnt_d   = '0;
      sd_d    = 1'b0;
    end else if (fall) begin
      sd_d = 1'b0;
      if (cnt_q < CNT_LAST) begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q < CNT_DATA) begin
          sd_d    = shift_q[DATA_W-1];
          shift_d = {shift_q[DATA_W-2:0], 1'b0};
        end
      end
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_IDLE;
      sck_q       <= 1'b0;
      ws_last_q   <= 1'b0;
      pend_full_q <= 1'b0;
      pend_l_q    <= '0;
      pend_r_q    <= '0;
      act_l_q     <= '0;
      act_r_q     <= '0;
      shift_q     <= '0;
      cnt_q       <= CNT_IDLE;
      sd_q        <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      sck_q       <= sck_d;
      ws_last_q   <= ws_last_d;
      pend_full_q <= pend_full_d;
      pend_l_q    <= pend_l_d;
      pend_r_q    <= pend_r_d;
      act_l_q     <= act_l_d;
      act_r_q     <= act_r_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      sd_q        <= sd_d;
      underrun_q  <= underrun_d;
    end
  end

  assign ready_o    = ~pend_full_q;
  assign sd_o       = sd_q;
  assign underrun_o = underrun_q;

endmodule

// File: tb/tb_i2s_transmit_24.sv
// Directed bench for i2s_transmit_24: SCK at clk/8, 64 SCK per frame, with a
// bench-side I2S receiver that captures each slot on SCK rising edges.
module tb_i2s_transmit_24;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        sck;
  logic        ws;
  logic [23:0] left_d;
  logic [23:0] right_d;
  logic        valid;
  logic        ready_o;
  logic        sd_o;
  logic        underrun_o;

  int vectors    = 0;
  int miscompares = 0;

  // generator / receiver state
  logic        sck_en = 1'b0;
  int          fall_cnt = 40;
  int          fs_count = 0;
  int          under_hi = 0;
  logic [23:0] cap = '0;
  logic        pad_bad = 1'b0;
  logic [25:0] capq[$];   // {chan, pad_bad, data}

  always #5 clk = ~clk;

  i2s_transmit_24 #(.DATA_W(24), .SLOT_W(32)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .sck_i      (sck),
    .ws_i       (ws),
    .left_i     (left_d),
    .right_i    (right_d),
    .valid_i    (valid),
    .ready_o    (ready_o),
    .sd_o       (sd_o),
    .underrun_o (underrun_o)
  );

  // SCK/WS source plus slot receiver; WS changes with SCK falling edges
  initial begin
    int pos;
    logic chan;
    sck = 1'b0;
    ws  = 1'b1;
    forever begin
      repeat (4) @(negedge clk);
      if (sck_en) begin
        if (!sck) begin
          sck  = 1'b1;
          pos  = fall_cnt % 32 + 1;
          chan = (fall_cnt >= 32);
          if (pos == 1) begin
            cap     = '0;
            pad_bad = (sd_o !== 1'b0);
          end else if (pos <= 25) begin
            cap = {cap[22:0], sd_o};
          end else if (sd_o !== 1'b0) begin
            pad_bad = 1'b1;
          end
          if (pos == 32) capq.push_back({chan, pad_bad, cap});
        end else begin
          sck      = 1'b0;
          fall_cnt = (fall_cnt + 1) % 64;
          ws       = (fall_cnt >= 32);
          if (fall_cnt == 0) fs_count++;
        end
      end
    end
  end

  always @(negedge clk) if (underrun_o === 1'b1) under_hi++;

  task automatic wait_fs();
    int f0 = fs_count;
    int n = 0;
    while (fs_count == f0 && n < 3000) begin @(negedge clk); #1; n++; end
    if (fs_count == f0) begin
      vectors++; miscompares++;
      $display("FAIL wait_fs: no frame start within %0d cycles", n);
    end
  endtask

  task automatic get_slot(output logic [25:0] e);
    int n = 0;
    while (capq.size() == 0 && n < 3000) begin @(negedge clk); #1; n++; end
    if (capq.size() == 0) begin
      vectors++; miscompares++;
      $display("FAIL get_slot: no slot captured within %0d cycles", n);
      e = '1;
    end else begin
      e = capq.pop_front();
    end
  endtask

  task automatic send_pair(input logic [23:0] l, input logic [23:0] r);
    int n = 0;
    left_d = l; right_d = r; valid = 1'b1;
    while (ready_o !== 1'b1 && n < 3000) begin @(negedge clk); #1; n++; end
    if (ready_o !== 1'b1) begin
      vectors++; miscompares++;
      $display("FAIL send_pair: ready_o stuck low, got %b required 1", ready_o);
    end
    @(posedge clk);
    @(negedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic test_reset();
    int ones = 0;
    int n = 0;
    int f0;
    logic [25:0] e;
    rst_n = 1'b0; valid = 1'b0; left_d = '0; right_d = '0;
    repeat (3) @(negedge clk); #1;
    vectors++; if (sd_o !== 1'b0) begin miscompares++; $display("FAIL reset_sd: got %b required 0", sd_o); end
    vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b required 1", ready_o); end
    vectors++; if (underrun_o !== 1'b0) begin miscompares++; $display("FAIL reset_underrun: got %b required 0", underrun_o); end
    rst_n = 1'b1;
    sck_en = 1'b1;
    f0 = fs_count;
    while (fs_count == f0 && n < 3000) begin
      if (sd_o !== 1'b0) ones++;
      @(negedge clk); #1; n++;
    end
    vectors++; if (fs_count == f0) begin miscompares++; $display("FAIL reset_first_fs: no frame start, got %0d required %0d", fs_count, f0 + 1); end
    vectors++; if (ones != 0) begin miscompares++; $display("FAIL reset_quiet: sd_o high cycles got %0d required 0", ones); end
    vectors++; if (under_hi != 0) begin miscompares++; $display("FAIL reset_no_early_underrun: got %0d required 0", under_hi); end
    capq.delete();
    repeat (3) @(negedge clk); #1;
    vectors++; if (under_hi != 1) begin miscompares++; $display("FAIL reset_first_underrun: pulse cycles got %0d required 1", under_hi); end
    get_slot(e);
    vectors++; if (e !== {1'b0, 1'b0, 24'h000000}) begin miscompares++; $display("FAIL reset_frame1_left: got %h required %h", e, {1'b0, 1'b0, 24'h000000}); end
    get_slot(e);
    vectors++; if (e !== {1'b1, 1'b0, 24'h000000}) begin miscompares++; $display("FAIL reset_frame1_right: got %h required %h", e, {1'b1, 1'b0, 24'h000000}); end
  endtask

  task automatic test_basic();
    int u0 = under_hi;
    logic [25:0] e;
    send_pair(24'hA5A5A5, 24'h3C3C3C);
    wait_fs();
    capq.delete();
    get_slot(e);
    vectors++; if (e !== {1'b0, 1'b0, 24'hA5A5A5}) begin miscompares++; $display("FAIL basic_left: got %h required %h", e, {1'b0, 1'b0, 24'hA5A5A5}); end
    get_slot(e);
    vectors++; if (e !== {1'b1, 1'b0, 24'h3C3C3C}) begin miscompares++; $display("FAIL basic_right: got %h required %h", e, {1'b1, 1'b0, 24'h3C3C3C}); end
    vectors++; if (under_hi != u0) begin miscompares++; $display("FAIL basic_underrun: pulse count got %0d required %0d", under_hi, u0); end
  endtask

  task automatic test_back_to_back();
    int u0 = under_hi;
    int f0;
    int n = 0;
    int bad_ready = 0;
    logic [25:0] e;
    send_pair(24'h000001, 24'h000002);
    vectors++; if (ready_o !== 1'b0) begin miscompares++; $display("FAIL b2b_ready_after_accept: got %b required 0", ready_o); end
    left_d = 24'h800000; right_d = 24'h7FFFFF; valid = 1'b1;
    f0 = fs_count;
    while (fs_count == f0 && n < 3000) begin
      if (ready_o !== 1'b0) bad_ready++;
      @(negedge clk); #1; n++;
    end
    if (ready_o !== 1'b0) bad_ready++;
    vectors++; if (bad_ready != 0 || fs_count == f0) begin miscompares++; $display("FAIL b2b_ready_held_low: high cycles got %0d required 0 (frame start seen %0d)", bad_ready, fs_count != f0); end
    @(negedge clk); #1;
    vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL b2b_ready_after_fs: got %b required 1", ready_o); end
    @(posedge clk);
    @(negedge clk); #1;
    valid = 1'b0;
    vectors++; if (ready_o !== 1'b0) begin miscompares++; $display("FAIL b2b_second_accept: ready got %b required 0", ready_o); end
    capq.delete();
    get_slot(e);
    vectors++; if (e !== {1'b0, 1'b0, 24'h000001}) begin miscompares++; $display("FAIL b2b_f1_left: got %h required %h", e, {1'b0, 1'b0, 24'h000001}); end
    get_slot(e);
    vectors++; if (e !== {1'b1, 1'b0, 24'h000002}) begin miscompares++; $display("FAIL b2b_f1_right: got %h required %h", e, {1'b1, 1'b0, 24'h000002}); end
    get_slot(e);
    vectors++; if (e !== {1'b0, 1'b0, 24'h800000}) begin miscompares++; $display("FAIL b2b_f2_left: got %h required %h", e, {1'b0, 1'b0, 24'h800000}); end
    get_slot(e);
    vectors++; if (e !== {1'b1, 1'b0, 24'h7FFFFF}) begin miscompares++; $display("FAIL b2b_f2_right: got %h required %h", e, {1'b1, 1'b0, 24'h7FFFFF}); end
    vectors++; if (under_hi != u0) begin miscompares++; $display("FAIL b2b_underrun: pulse count got %0d required %0d", under_hi, u0); end
  endtask

  task automatic test_underrun();
    int u0 = under_hi;
    logic [25:0] e;
    wait_fs();
    capq.delete();
    repeat (3) @(negedge clk); #1;
    vectors++; if (under_hi != u0 + 1) begin miscompares++; $display("FAIL underrun_pulse: cycles got %0d required %0d", under_hi - u0, 1); end
    get_slot(e);
    vectors++; if (e !== {1'b0, 1'b0, 24'h000000}) begin miscompares++; $display("FAIL underrun_left: got %h required %h", e, {1'b0, 1'b0, 24'h000000}); end
    get_slot(e);
    vectors++; if (e !== {1'b1, 1'b0, 24'h000000}) begin miscompares++; $display("FAIL underrun_right: got %h required %h", e, {1'b1, 1'b0, 24'h000000}); end
    // offer a pair in the very cycle the frame start is detected
    wait_fs();
    left_d = 24'h5A5A5A; right_d = 24'hC3C3C3; valid = 1'b1;
    @(posedge clk);
    @(negedge clk); #1;
    valid = 1'b0;
    vectors++; if (ready_o !== 1'b0) begin miscompares++; $display("FAIL same_cycle_accept: ready got %b required 0", ready_o); end
    capq.delete();
    repeat (2) @(negedge clk); #1;
    vectors++; if (under_hi != u0 + 2) begin miscompares++; $display("FAIL same_cycle_underrun: pulses got %0d required %0d", under_hi - u0, 2); end
    get_slot(e);
    vectors++; if (e !== {1'b0, 1'b0, 24'h000000}) begin miscompares++; $display("FAIL same_cycle_left0: got %h required %h", e, {1'b0, 1'b0, 24'h000000}); end
    get_slot(e);
    vectors++; if (e !== {1'b1, 1'b0, 24'h000000}) begin miscompares++; $display("FAIL same_cycle_right0: got %h required %h", e, {1'b1, 1'b0, 24'h000000}); end
    get_slot(e);
    vectors++; if (e !== {1'b0, 1'b0, 24'h5A5A5A}) begin miscompares++; $display("FAIL next_frame_left: got %h required %h", e, {1'b0, 1'b0, 24'h5A5A5A}); end
    get_slot(e);
    vectors++; if (e !== {1'b1, 1'b0, 24'hC3C3C3}) begin miscompares++; $display("FAIL next_frame_right: got %h required %h", e, {1'b1, 1'b0, 24'hC3C3C3}); end
    vectors++; if (under_hi != u0 + 2) begin miscompares++; $display("FAIL next_frame_underrun: pulses got %0d required %0d", under_hi - u0, 2); end
  endtask

  task automatic test_reset_midframe();
    int n = 0;
    int ones = 0;
    int f0;
    int u_r;
    logic [25:0] e;
    send_pair(24'hFFFFFF, 24'h000000);
    wait_fs();
    send_pair(24'h0F0F0F, 24'h0F0F0F);
    while (fall_cnt != 10 && n < 3000) begin @(negedge clk); #1; n++; end
    repeat (2) @(negedge clk); #1;
    vectors++; if (sd_o !== 1'b1) begin miscompares++; $display("FAIL midframe_bit10: sd got %b required 1", sd_o); end
    vectors++; if (ready_o !== 1'b0) begin miscompares++; $display("FAIL midframe_pending: ready got %b required 0", ready_o); end
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (sd_o !== 1'b0) begin miscompares++; $display("FAIL midframe_rst_sd: got %b required 0", sd_o); end
    vectors++; if (ready_o !== 1'b1) begin miscompares++; $display("FAIL midframe_rst_ready: got %b required 1", ready_o); end
    repeat (3) @(negedge clk); #1;
    rst_n = 1'b1;
    u_r = under_hi;
    send_pair(24'h123456, 24'hABCDEF);
    f0 = fs_count;
    n = 0;
    while (fs_count == f0 && n < 3000) begin
      if (sd_o !== 1'b0) ones++;
      @(negedge clk); #1; n++;
    end
    vectors++; if (ones != 0 || fs_count == f0) begin miscompares++; $display("FAIL post_reset_quiet: sd high cycles got %0d required 0 (frame start seen %0d)", ones, fs_count != f0); end
    capq.delete();
    get_slot(e);
    vectors++; if (e !== {1'b0, 1'b0, 24'h123456}) begin miscompares++; $display("FAIL post_reset_left: got %h required %h", e, {1'b0, 1'b0, 24'h123456}); end
    get_slot(e);
    vectors++; if (e !== {1'b1, 1'b0, 24'hABCDEF}) begin miscompares++; $display("FAIL post_reset_right: got %h required %h", e, {1'b1, 1'b0, 24'hABCDEF}); end
    vectors++; if (under_hi != u_r) begin miscompares++; $display("FAIL post_reset_underrun: pulses got %0d required %0d", under_hi, u_r); end
  endtask

  task automatic test_loopback();
    logic [23:0] exp_l[16];
    logic [23:0] exp_r[16];
    int u0 = under_hi;
    for (int i = 0; i < 16; i++) begin
      exp_l[i] = 24'($urandom);
      exp_r[i] = 24'($urandom);
    end
    fork
      begin
        for (int i = 0; i < 16; i++) send_pair(exp_l[i], exp_r[i]);
      end
      begin
        logic [25:0] e;
        for (int k = 0; k < 16; k++) begin
          get_slot(e);
          vectors++; if (e !== {1'b0, 1'b0, exp_l[k]}) begin miscompares++; $display("FAIL loop_left[%0d]: got %h required %h", k, e, {1'b0, 1'b0, exp_l[k]}); end
          get_slot(e);
          vectors++; if (e !== {1'b1, 1'b0, exp_r[k]}) begin miscompares++; $display("FAIL loop_right[%0d]: got %h required %h", k, e, {1'b1, 1'b0, exp_r[k]}); end
        end
      end
    join
    vectors++; if (under_hi != u0) begin miscompares++; $display("FAIL loop_underrun: pulses got %0d required %0d", under_hi - u0, 0); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_underrun();
    test_reset_midframe();
    test_loopback();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/i2s_transmit_24.md
Name: i2s_transmit_24

Overview:
- I2S transmitter: the transmit-side counterpart of the 24-bit I2S capture path. It serializes a left/right 24-bit sample pair onto sd_o each frame.
- Uses the same sck/ws pair produced by the I2S clock generator, which runs in the clk_i domain, so no CDC is needed.
- Samples are accepted through a valid/ready handshake into a one-pair pending buffer. The pair is transferred to the shift stage at each frame start.
- Used for DAC/codec playback and for loopback verification of the capture path.

Parameters:
- DATA_W, 24, sample width in bits; MSB-first, left-justified in the slot.
- SLOT_W, 32, SCK periods per channel slot; must be >= DATA_W+1.

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  asynchronous active-low reset.
- sck_i  input  1  I2S bit clock from the clock generator; synchronous to clk_i.
- ws_i  input  1  I2S word select; 0=left, 1=right; changes together with the falling edge of sck_i.
- left_i  input  DATA_W  left sample, two's complement.
- right_i  input  DATA_W  right sample, two's complement.
- valid_i  input  1  sample pair valid.
- ready_o  output  1  pending buffer empty; pair accepted on valid_i && ready_o.
- sd_o  output  1  serial data; changes only in the clk_i cycle of a detected SCK falling edge.
- underrun_o  output  1  one-cycle pulse: frame started with no pending pair.

Behaviour:
- Reset values: sd_o=0, ready_o=1, underrun_o=0. Pending buffer empty, active L/R words=0, bit counter=SLOT_W (idle).
- Reset values of internal registers: sck_q=0, ws_last=0, frame_armed=0.
- Reset is asynchronous; all state returns to reset values immediately, including mid-frame.
- SCK falling edge (fall) = sck_q && !sck_i, where sck_q is sck_i registered every clk_i cycle.
- ws_last is updated only on fall, and takes ws_i.
- WS transition = fall && (ws_i != ws_last).
- Frame start = WS transition 1->0.
- Frame start actions:
  - If pending is full: copy pending L and R to the active words, empty pending, ready_o=1 from the next cycle.
  - If pending is empty: active words = 0, underrun_o=1 for exactly one cycle.
  - Set frame_armed=1.
- Right-slot start (WS 0->1) uses the active right word latched at the preceding frame start, so L/R stay coherent within a frame.
- Slot start actions (any WS transition with frame_armed=1):
  - Load shift register with the channel's active word; bit counter=0.
  - sd_o is driven 0 on this fall; this is the I2S one-bit delay / last padding bit of the previous slot.
- On each subsequent fall, counter c counts 1..SLOT_W-1:
  - c in 1..DATA_W: sd_o = word[DATA_W-c], so the MSB goes out first.
  - c > DATA_W: sd_o=0 (padding).
  - Counter saturates at SLOT_W-1; sd_o=0 until the next WS transition. This covers an overlong slot from a malformed clock.
- Before the first frame start after reset (frame_armed=0): sd_o=0, and a WS 0->1 transition is ignored. The first partial frame is never transmitted.
- Handshake:
  - valid_i && ready_o: latch left_i/right_i into pending; ready_o=0 next cycle.
  - ready_o is independent of valid_i, with no combinational path.
  - valid_i with ready_o=0: no effect; the source holds the data.
- Simultaneous accept and frame start with pending empty: underrun_o pulses and active words = 0. The newly accepted pair stays pending for the next frame; there is no bypass.
- Simultaneous accept and frame start with pending full: not possible, since ready_o=0.
- Latency: an accepted pair is transmitted in the first frame whose start occurs at least one cycle after acceptance. Its MSB appears on the second SCK falling edge of that frame.
- Timing: sd_o is stable from a falling edge through the following rising edge. The receiver samples on the SCK rising edge.

Test Plan:
1. Reset check, in three steps:
   - Hold rst_ni=0 → sd_o=0, ready_o=1, underrun_o=0.
   - Release with ws_i=1, then drive sck at clk/8 with 64 SCK/frame → no sd_o activity before the first WS 1->0.
   - The WS 0->1 transition before that frame start is ignored.
2. Basic frame:
   - Stimulus: accept L=0xA5A5A5, R=0x3C3C3C before the frame start.
   - Left slot, bits sampled on SCK rises 2..25 → 0xA5A5A5 MSB-first; rises 26..32 and rise 1 → 0.
   - Right slot → 0x3C3C3C in the same positions.
   - underrun_o stays 0.
3. Back-pressure: two consecutive valid_i pairs (0x000001/0x000002, then 0x800000/0x7FFFFF) → ready_o=0 after the first until the frame start. The second pair is accepted the cycle after, and is transmitted in the following frame with exact bit values.
4. Underrun: no pair offered → underrun_o one-cycle pulse at each frame start; both slots all zeros. A pair accepted in the same cycle as frame start → underrun still flagged, and the pair is sent in the next frame.
5. Reset mid-frame: assert rst_ni during left bit 10 of 0xFFFFFF → sd_o=0 immediately and ready_o=1. After release, no output until a fresh WS 1->0; then normal operation.
6. Loopback: sd_o drives the 24-bit I2S capture block on the same sck/ws, streaming 16 random pairs → captured left/right equal the transmitted values in order, with no underrun pulse when the source keeps up.
